// File: rtl/pkt_sender_pkg.sv
// Shared types for the packet sender: FSM state encoding.
package pkt_sender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_t;

endpackage : pkt_sender_pkg

// File: rtl/pkt_buf_ram.sv
// Simple dual-port packet buffer with a registered, enable-gated read port.
module pkt_buf_ram #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value when not reading, so it doubles as the packet data output.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : pkt_buf_ram

// File: rtl/pkt_sender.sv
// Buffers one packet of up to 2**AWIDTH words, then streams it out with sop/eop once downstream is free.
module pkt_sender
  import pkt_sender_pkg::*;
#(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] wrdata_i,
  input  logic              wren_i,
  input  logic              wrlast_i,
  output logic              wrready_o,
  input  logic              busy_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              val_o,
  output logic              tx_busy_o
);

  localparam int unsigned CWIDTH = AWIDTH + 1;
  localparam int unsigned DEPTH  = 2 ** AWIDTH;
  localparam logic [CWIDTH-1:0] FULL = CWIDTH'(DEPTH);
  localparam logic [CWIDTH-1:0] ONE  = CWIDTH'(1);

  state_t state, state_nxt;

  logic [CWIDTH-1:0] count, count_nxt;
  logic [CWIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic              val_nxt, sop_nxt, eop_nxt;
  logic              wrready_nxt, tx_busy_nxt;

  logic              wr_en_c;
  logic [AWIDTH-1:0] wr_addr_c;
  logic              rd_en_c;
  logic [AWIDTH-1:0] rd_addr_c;

  pkt_buf_ram #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk     (clk_i),
    .srst    (srst_i),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (wrdata_i),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_c),
    .rd_data (data_o)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, buffer control and next output values.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    val_nxt    = 1'b0;
    sop_nxt    = 1'b0;
    eop_nxt    = 1'b0;
    wr_en_c    = wren_i && wrready_o;
    wr_addr_c  = count[AWIDTH-1:0];
    rd_en_c    = 1'b0;
    rd_addr_c  = rd_ptr[AWIDTH-1:0];

    unique case (state)
      IDLE: begin
        if (wr_en_c) begin
          wr_addr_c = '0;
          count_nxt = ONE;
          state_nxt = wrlast_i ? WAIT : LOAD;
        end
      end
      LOAD: begin
        if (wr_en_c) begin
          count_nxt = count + ONE;
          if (wrlast_i || (count_nxt == FULL)) begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // Word 0 is fetched on the same edge that enters SEND, so sop lands on the first SEND cycle.
        if (!busy_i) begin
          rd_en_c    = 1'b1;
          rd_addr_c  = '0;
          rd_ptr_nxt = ONE;
          val_nxt    = 1'b1;
          sop_nxt    = 1'b1;
          eop_nxt    = (count == ONE);
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (rd_ptr == count) begin
          state_nxt = IDLE;
        end else begin
          rd_en_c    = 1'b1;
          rd_ptr_nxt = rd_ptr + ONE;
          val_nxt    = 1'b1;
          eop_nxt    = (rd_ptr_nxt == count);
        end
      end
    endcase

    wrready_nxt = (state_nxt == IDLE) || (state_nxt == LOAD);
    tx_busy_nxt = (state_nxt == WAIT) || (state_nxt == SEND);
  end

  // Counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count     <= '0;
      rd_ptr    <= '0;
      val_o     <= 1'b0;
      sop_o     <= 1'b0;
      eop_o     <= 1'b0;
      wrready_o <= 1'b1;
      tx_busy_o <= 1'b0;
    end else begin
      count     <= count_nxt;
      rd_ptr    <= rd_ptr_nxt;
      val_o     <= val_nxt;
      sop_o     <= sop_nxt;
      eop_o     <= eop_nxt;
      wrready_o <= wrready_nxt;
      tx_busy_o <= tx_busy_nxt;
    end
  end

endmodule : pkt_sender
